// File: rtl/keypad_scanner_pkg.sv
// Shared calculator key-event definitions: operator codes, scanner states and
// the 4x4 key map. The calculator FSM imports the same operator codes.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    HOLD     = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    EV_NUM,
    EV_OP,
    EV_EQ,
    EV_CLR
  } key_kind_e;

  typedef struct packed {
    key_kind_e  kind;
    logic [3:0] num;
    op_e        op;
  } key_event_t;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KC_A    = 4'd10;
  localparam key_code_t KC_B    = 4'd11;
  localparam key_code_t KC_C    = 4'd12;
  localparam key_code_t KC_D    = 4'd13;
  localparam key_code_t KC_STAR = 4'd14;
  localparam key_code_t KC_HASH = 4'd15;

  // Indexed by {row, col}; rows top to bottom, columns left to right.
  localparam key_code_t KEY_MAP [16] = '{
    4'd1,    4'd2, 4'd3,    KC_A,
    4'd4,    4'd5, 4'd6,    KC_B,
    4'd7,    4'd8, 4'd9,    KC_C,
    KC_STAR, 4'd0, KC_HASH, KC_D
  };

  // True when exactly one active-low line is asserted.
  function automatic logic one_low(input logic [3:0] rows);
    logic [3:0] act;
    act = ~rows;
    return (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs that idle
// high; resets to all-ones so a pulled-up line reads inactive out of reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row debounce, and one registered
// single-cycle key event per accepted press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       is_num,
  output logic [3:0] num_val,
  output logic       is_op,
  output logic [1:0] op_val,
  output logic       is_eq,
  output logic       is_clr
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);

  function automatic logic [1:0] row_index(input logic [3:0] rows);
    case (~rows)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic key_event_t decode_key(input logic [1:0] row, input logic [1:0] col);
    key_event_t ev;
    key_code_t  code;
    code    = KEY_MAP[{row, col}];
    ev.kind = EV_NUM;
    ev.num  = code;
    ev.op   = OP_ADD;
    case (code)
      KC_A:    begin ev.kind = EV_OP; ev.op = OP_ADD; end
      KC_B:    begin ev.kind = EV_OP; ev.op = OP_SUB; end
      KC_C:    begin ev.kind = EV_OP; ev.op = OP_MUL; end
      KC_D:    begin ev.kind = EV_OP; ev.op = OP_DIV; end
      KC_STAR: ev.kind = EV_CLR;
      KC_HASH: ev.kind = EV_EQ;
      default: ;
    endcase
    return ev;
  endfunction

  logic [3:0] w_rows_s;
  key_event_t w_ev;

  scan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_col_n;
  logic [1:0]       r_col;
  logic [1:0]       r_row;
  logic [3:0]       r_row_pat;
  logic             r_is_num;
  logic             r_is_op;
  logic             r_is_eq;
  logic             r_is_clr;
  logic [3:0]       r_num_val;
  op_e              r_op_val;

  sync2 #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .rst_n (rst),
    .i_d   (row_n),
    .o_q   (w_rows_s)
  );

  assign w_ev = decode_key(r_row, r_col);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= SCAN;
      r_cnt     <= '0;
      r_col_n   <= 4'b1110;
      r_col     <= 2'd0;
      r_row     <= 2'd0;
      r_row_pat <= 4'b1111;
      r_is_num  <= 1'b0;
      r_is_op   <= 1'b0;
      r_is_eq   <= 1'b0;
      r_is_clr  <= 1'b0;
      r_num_val <= 4'd0;
      r_op_val  <= OP_ADD;
    end else begin
      // NOTE: strobes default low every cycle and are only raised on the
      // DEBOUNCE->EMIT edge, so each accepted press yields exactly one pulse.
      r_is_num <= 1'b0;
      r_is_op  <= 1'b0;
      r_is_eq  <= 1'b0;
      r_is_clr <= 1'b0;

      case (r_state)
        SCAN: begin
          if (r_cnt == SCAN_LAST) begin
            r_cnt <= '0;
            if (one_low(w_rows_s)) begin
              r_row     <= row_index(w_rows_s);
              r_row_pat <= w_rows_s;
              r_state   <= DEBOUNCE;
            end else begin
              r_col   <= r_col + 2'd1;
              r_col_n <= {r_col_n[2:0], r_col_n[3]};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (w_rows_s != r_row_pat) begin
            r_cnt   <= '0;
            r_state <= SCAN;
          end else if (r_cnt == DEB_LAST) begin
            r_cnt   <= '0;
            r_state <= EMIT;
            case (w_ev.kind)
              EV_NUM: begin r_is_num <= 1'b1; r_num_val <= w_ev.num; end
              EV_OP:  begin r_is_op  <= 1'b1; r_op_val  <= w_ev.op;  end
              EV_EQ:  r_is_eq  <= 1'b1;
              EV_CLR: r_is_clr <= 1'b1;
            endcase
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        EMIT: begin
          r_cnt   <= '0;
          r_state <= HOLD;
        end

        HOLD: begin
          // Any low row restarts the release count; a held key never re-emits.
          if (w_rows_s != 4'b1111) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_cnt   <= '0;
            r_state <= SCAN;
            r_col   <= r_col + 2'd1;
            r_col_n <= {r_col_n[2:0], r_col_n[3]};
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= SCAN;
      endcase
    end
  end

  assign col_n   = r_col_n;
  assign is_num  = r_is_num;
  assign num_val = r_num_val;
  assign is_op   = r_is_op;
  assign op_val  = r_op_val;
  assign is_eq   = r_is_eq;
  assign is_clr  = r_is_clr;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural 4x4 keypad drives row_n
// from col_n, and a monitor counts the strobes each scenario produces.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       is_num;
  logic [3:0] num_val;
  logic       is_op;
  logic [1:0] op_val;
  logic       is_eq;
  logic       is_clr;

  logic [15:0] key_down;

  int n_checks = 0;
  int n_errors = 0;

  int n_num = 0, n_op = 0, n_eq = 0, n_clr = 0, n_multi = 0;
  logic [3:0] last_num = 4'd0;
  logic [1:0] last_op  = 2'd0;
  int b_num, b_op, b_eq, b_clr;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_n   (row_n),
    .col_n   (col_n),
    .is_num  (is_num),
    .num_val (num_val),
    .is_op   (is_op),
    .op_val  (op_val),
    .is_eq   (is_eq),
    .is_clr  (is_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key index r*4+c pulls row r low while column c is driven low.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (is_num) begin n_num <= n_num + 1; last_num <= num_val; end
      if (is_op)  begin n_op  <= n_op  + 1; last_op  <= op_val;  end
      if (is_eq)  n_eq  <= n_eq  + 1;
      if (is_clr) n_clr <= n_clr + 1;
      if (int'(is_num) + int'(is_op) + int'(is_eq) + int'(is_clr) > 1)
        n_multi <= n_multi + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    b_num = n_num;
    b_op  = n_op;
    b_eq  = n_eq;
    b_clr = n_clr;
  endtask

  task automatic wait_col(input logic [3:0] target, input string tag);
    int t = 0;
    while (col_n !== target && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(tag, col_n, target);
  endtask

  task automatic press_release(input int key, input int hold, input int gap);
    key_down[key] = 1'b1;
    tick(hold);
    key_down[key] = 1'b0;
    tick(gap);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [3:0] prev;
    logic [3:0] seq [4];

    rst      = 1'b0;
    key_down = 16'd0;
    tick(3);
    check("rst_col_n",   col_n, 4'b1110);
    check("rst_strobes", {is_num, is_op, is_eq, is_clr}, 4'b0000);
    check("rst_num_val", num_val, 4'd0);
    check("rst_op_val",  op_val, 2'd0);
    rst = 1'b1;

    // '7' (row2, col0): latency from col0 drive = SCAN_DIV + DEBOUNCE_CYC = 12.
    mark();
    wait_col(4'b0111, "wait_col3");
    key_down[8] = 1'b1;
    wait_col(4'b1110, "wait_col0");
    lat = 0;
    while (!is_num && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("lat_7", lat, 12);
    tick(190);
    key_down[8] = 1'b0;
    tick(100);
    check("num7_count", n_num - b_num, 1);
    check("num7_val",   last_num, 4'd7);
    check("num7_other", (n_op + n_eq + n_clr) - (b_op + b_eq + b_clr), 0);

    // 'C' then '#' then '*'.
    mark();
    press_release(11, 100, 100);
    check("opC_count", n_op - b_op, 1);
    check("opC_val",   last_op, 2'b10);
    check("opC_other", (n_num + n_eq + n_clr) - (b_num + b_eq + b_clr), 0);
    mark();
    press_release(14, 100, 100);
    check("eq_count", n_eq - b_eq, 1);
    check("eq_other", (n_num + n_op + n_clr) - (b_num + b_op + b_clr), 0);
    mark();
    press_release(12, 100, 100);
    check("clr_count", n_clr - b_clr, 1);
    check("clr_other", (n_num + n_op + n_eq) - (b_num + b_op + b_eq), 0);

    // '5' with press bounce every 3 cycles, then stable.
    mark();
    for (int i = 0; i < 10; i++) begin
      key_down[5] = (i % 2 == 0);
      tick(3);
    end
    press_release(5, 100, 100);
    check("num5_count", n_num - b_num, 1);
    check("num5_val",   last_num, 4'd5);

    // '0' held long (no auto-repeat), short release bounce, then pressed again.
    mark();
    key_down[13] = 1'b1;
    tick(500);
    check("num0_hold_count", n_num - b_num, 1);
    key_down[13] = 1'b0; tick(1);
    key_down[13] = 1'b1; tick(1);
    key_down[13] = 1'b0; tick(1);
    key_down[13] = 1'b1; tick(1);
    key_down[13] = 1'b0;
    tick(100);
    check("num0_bounce_count", n_num - b_num, 1);
    press_release(13, 100, 100);
    check("num0_count", n_num - b_num, 2);
    check("num0_val",   last_num, 4'd0);

    // '2' and '5' together: two rows low on col1 must be ignored.
    key_down[1] = 1'b1;
    key_down[5] = 1'b1;
    mark();
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    wait_col(4'b1110, "multi_start");
    for (int k = 0; k < 4; k++) begin
      prev = col_n;
      lat  = 0;
      while (col_n === prev && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("multi_seq%0d", k), col_n, seq[k]);
    end
    tick(40);
    check("multi_none", (n_num + n_op + n_eq + n_clr) - (b_num + b_op + b_eq + b_clr), 0);
    key_down[1] = 1'b0;
    key_down[5] = 1'b0;
    tick(50);

    // Reset while '3' (row0, col2) is being debounced.
    mark();
    key_down[2] = 1'b1;
    wait_col(4'b1011, "wait_col2");
    tick(6);
    rst = 1'b0;
    #1;
    check("midrst_col_n",   col_n, 4'b1110);
    check("midrst_strobes", {is_num, is_op, is_eq, is_clr}, 4'b0000);
    check("midrst_num_val", num_val, 4'd0);
    check("midrst_op_val",  op_val, 2'd0);
    check("midrst_no_emit", n_num - b_num, 0);
    tick(3);
    rst = 1'b1;
    mark();
    tick(100);
    key_down[2] = 1'b0;
    tick(100);
    check("num3_count", n_num - b_num, 1);
    check("num3_val",   last_num, 4'd3);

    check("exclusive", n_multi, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
